alu_op_sequencer: RTL and testbench

Sequences operations into the shared 4-bit ALU and the 3-bit result write-address stream. Requesters push {opcode, A, B} commands through a valid/ready port into a small FIFO. An FSM issues each command to the ALU, waits for its done pulse (with timeout), then emits one write beat carrying the 8-bit result, the flags, and an auto-incrementing write address. Sits between the command source and the ALU/result-store pair.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/cmd_fifo.sv | 55 +++++
 rtl/alu_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, command/flag records and sequencer state encoding for the
// ALU operation sequencer and its command FIFO.
package alu_pkg;

    localparam int OPC_W           = 4;
    localparam int OPND_W          = 4;
    localparam int RES_W           = 8;
    localparam int ADDR_W          = 3;
    localparam int DEFAULT_NUM_OPS = 10;

    typedef struct packed {
        logic gt;
        logic st;
        logic eq;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_e;

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op, input int num_ops);
        return int'(op) < num_ops;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for queued ALU commands; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; emptiness comes from the pointers, so stale data is never read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues {opcode, A, B} commands, issues each to the shared ALU, waits for
// done with a timeout, and emits one write beat per completed command.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_OPS    = DEFAULT_NUM_OPS,
    parameter int TIMEOUT    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPC_W-1:0]  cmd_opcode,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    output logic              alu_start,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_result,
    input  logic [3:0]        alu_flags,
    input  logic              alu_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [RES_W-1:0]  wr_data,
    output logic [3:0]        wr_flags,
    output logic              busy,
    output logic              err_opcode,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abort on the WAIT cycle whose increment would reach TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    seq_state_e        state_q, state_d;
    alu_cmd_t          alu_cmd_q, alu_cmd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [RES_W-1:0]  wr_data_q, wr_data_d;
    alu_flags_t        wr_flags_q, wr_flags_d;
    logic              err_opcode_q, err_opcode_d;
    logic              err_timeout_q, err_timeout_d;

    alu_cmd_t          fifo_head;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              set_err_opcode, set_err_timeout;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (cmd_valid),
        .push_data ({cmd_opcode, cmd_a, cmd_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d         = state_q;
        alu_cmd_d       = alu_cmd_q;
        cnt_d           = cnt_q;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        wr_flags_d      = wr_flags_q;
        fifo_pop        = 1'b0;
        set_err_opcode  = 1'b0;
        set_err_timeout = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (is_legal_op(fifo_head.opcode, NUM_OPS)) begin
                        alu_cmd_d = fifo_head;
                        state_d   = ST_ISSUE;
                    end else begin
                        set_err_opcode = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    wr_data_d  = alu_result;
                    wr_flags_d = alu_flags_t'(alu_flags);
                    state_d    = ST_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    set_err_timeout = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear wins over a same-cycle set.
        err_opcode_d  = err_clr ? 1'b0 : (err_opcode_q  | set_err_opcode);
        err_timeout_d = err_clr ? 1'b0 : (err_timeout_q | set_err_timeout);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            alu_cmd_q     <= '0;
            cnt_q         <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_flags_q    <= '0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_cmd_q     <= alu_cmd_d;
            cnt_q         <= cnt_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_flags_q    <= wr_flags_d;
            err_opcode_q  <= err_opcode_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // A full FIFO still takes a push in the cycle the sequencer pops it.
    assign cmd_ready   = !fifo_full || fifo_pop;
    assign alu_start   = (state_q == ST_ISSUE);
    assign wr_en       = (state_q == ST_WRITE);
    assign alu_opcode  = alu_cmd_q.opcode;
    assign alu_a       = alu_cmd_q.a;
    assign alu_b       = alu_cmd_q.b;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_flags    = wr_flags_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign err_opcode  = err_opcode_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a command driver, a simple ALU model
// and a write-beat monitor all advance together, one call per clock cycle.
module tb_alu_op_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int NUM_OPS    = 10;
    localparam int TIMEOUT    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_opcode, cmd_a, cmd_b;
    logic       alu_start;
    logic [3:0] alu_opcode, alu_a, alu_b;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       alu_done;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] wr_flags;
    logic       busy, err_opcode, err_timeout, err_clr;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .NUM_OPS    (NUM_OPS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .alu_start   (alu_start),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .alu_done    (alu_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_flags    (wr_flags),
        .busy        (busy),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic [3:0] flags;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] cmd_q[$];
    int          wr_times[$];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          start_cnt = 0;
    int          wr_cnt = 0;
    bit          accept_pend, done_pend, alu_hang, saw_not_ready;
    logic [11:0] start_cmd;
    logic [2:0]  exp_addr;

    // Reference ALU: returns {result, flags{gt, st, eq, v}}.
    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] r;
        logic [3:0] f;
        case (op)
            4'd0:    r = {4'h0, a} + {4'h0, b};
            4'd1:    r = {4'h0, a} - {4'h0, b};
            4'd2:    r = {4'h0, a & b};
            4'd3:    r = {4'h0, a | b};
            4'd4:    r = {4'h0, a ^ b};
            4'd5:    r = {4'h0, a} * {4'h0, b};
            4'd6:    r = {a, b};
            4'd7:    r = {b, a};
            4'd8:    r = {4'h0, ~a};
            default: r = {2'b00, a, 2'b00};
        endcase
        f = {a > b, a < b, a == b, |r[7:4]};
        return {r, f};
    endfunction

    task automatic clear_tb();
        cmd_q.delete();
        exp_q.delete();
        accept_pend   = 1'b0;
        done_pend     = 1'b0;
        alu_hang      = 1'b0;
        saw_not_ready = 1'b0;
        exp_addr      = 3'd0;
        cmd_valid     = 1'b0;
        cmd_opcode    = 4'h0;
        cmd_a         = 4'h0;
        cmd_b         = 4'h0;
        alu_done      = 1'b0;
        alu_result    = 8'h00;
        alu_flags     = 4'h0;
        err_clr       = 1'b0;
    endtask

    // One clock cycle: driver, ALU model and write monitor, all at the negedge.
    task automatic tick();
        logic [11:0] m;
        exp_t        e;
        @(negedge clk);
        cyc++;
        if (accept_pend) begin
            void'(cmd_q.pop_front());
            accept_pend = 1'b0;
        end
        if (cmd_q.size() > 0) begin
            cmd_valid = 1'b1;
            {cmd_opcode, cmd_a, cmd_b} = cmd_q[0];
        end else begin
            cmd_valid = 1'b0;
        end
        accept_pend = cmd_valid && (cmd_ready === 1'b1);
        if (cmd_valid && cmd_ready === 1'b0) saw_not_ready = 1'b1;

        if (done_pend) begin
            m          = alu_model(alu_opcode, alu_a, alu_b);
            alu_done   = 1'b1;
            alu_result = m[11:4];
            alu_flags  = m[3:0];
            done_pend  = 1'b0;
            checks++;
            if ({alu_opcode, alu_a, alu_b} !== start_cmd) begin
                fails++;
                $display("FAIL alu_operands_held: got %h, held from issue %h", {alu_opcode, alu_a, alu_b}, start_cmd);
            end
        end else begin
            alu_done   = 1'b0;
            alu_result = 8'h00;
            alu_flags  = 4'h0;
        end
        if (alu_start === 1'b1) begin
            start_cnt++;
            start_cmd = {alu_opcode, alu_a, alu_b};
            if (!alu_hang) done_pend = 1'b1;
        end

        if (wr_en === 1'b1) begin
            wr_cnt++;
            wr_times.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h flags=%b, no write expected", wr_addr, wr_data, wr_flags);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data, wr_flags} !== {e.addr, e.data, e.flags}) begin
                    fails++;
                    $display("FAIL wr_beat: got addr=%0d data=%h flags=%b, expected addr=%0d data=%h flags=%b",
                             wr_addr, wr_data, wr_flags, e.addr, e.data, e.flags);
                end
            end
        end
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] data, input logic [3:0] flags);
        exp_t e;
        cmd_q.push_back({op, a, b});
        e.addr  = exp_addr;
        e.data  = data;
        e.flags = flags;
        exp_q.push_back(e);
        exp_addr = exp_addr + 3'd1;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [11:0] m;
        m = alu_model(op, a, b);
        push_exp(op, a, b, m[11:4], m[3:0]);
    endtask

    task automatic push_raw(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_q.push_back({op, a, b});
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_tb();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (cmd_q.size() != 0 || exp_q.size() != 0 || busy !== 1'b0 || done_pend) begin
            if (n == bound) begin
                checks++;
                fails++;
                $display("FAIL %s_drain: still busy after %0d cycles, %0d writes outstanding", name, bound, exp_q.size());
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic wait_start(input string name, input int bound);
        int s0;
        s0 = start_cnt;
        for (int n = 0; n < bound && start_cnt == s0; n++) tick();
        checks++;
        if (start_cnt == s0) begin
            fails++;
            $display("FAIL %s_start: got no alu_start within %0d cycles, expected one", name, bound);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_tb();
        @(negedge clk);
        checks++;
        if ({alu_start, wr_en, busy, err_opcode, err_timeout} !== 5'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b, expected 00000", {alu_start, wr_en, busy, err_opcode, err_timeout});
        end
        checks++;
        if ({alu_opcode, alu_a, alu_b} !== 12'h000) begin
            fails++;
            $display("FAIL reset_alu_regs: got %h, expected 000", {alu_opcode, alu_a, alu_b});
        end
        checks++;
        if ({wr_addr, wr_data, wr_flags} !== 15'h0) begin
            fails++;
            $display("FAIL reset_wr_regs: got addr=%0d data=%h flags=%b, expected zeros", wr_addr, wr_data, wr_flags);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got ready=%b busy=%b, expected ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        int s0, w0;
        apply_reset();
        s0 = start_cnt;
        w0 = wr_cnt;
        push_exp(4'd0, 4'd3, 4'd5, 8'h08, 4'b0100);
        drain("single", 40);
        checks++;
        if (start_cnt - s0 != 1 || wr_cnt - w0 != 1) begin
            fails++;
            $display("FAIL single_counts: got starts=%0d writes=%0d, expected 1 and 1", start_cnt - s0, wr_cnt - w0);
        end
        checks++;
        if (wr_addr !== 3'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_after: got wr_addr=%0d busy=%b, expected wr_addr=1 busy=0", wr_addr, busy);
        end
    endtask

    task automatic test_back_to_back();
        int w0, bad_gaps;
        apply_reset();
        w0 = wr_cnt;
        wr_times.delete();
        for (int i = 0; i < 9; i++) push_cmd(4'(i), 4'(i + 1), 4'(15 - i));
        drain("b2b", 200);
        checks++;
        if (wr_cnt - w0 != 9) begin
            fails++;
            $display("FAIL b2b_count: got %0d writes, expected 9", wr_cnt - w0);
        end
        checks++;
        if (!saw_not_ready) begin
            fails++;
            $display("FAIL b2b_backpressure: got cmd_ready never low, expected low once 4 queued");
        end
        bad_gaps = 0;
        for (int i = 1; i < wr_times.size(); i++)
            if (wr_times[i] - wr_times[i-1] != 4) bad_gaps++;
        checks++;
        if (bad_gaps != 0) begin
            fails++;
            $display("FAIL b2b_throughput: got %0d write gaps not 4 cycles apart, expected 0", bad_gaps);
        end
        checks++;
        if (wr_addr !== 3'd1) begin
            fails++;
            $display("FAIL b2b_wrap: got wr_addr=%0d, expected 1 after 9 writes", wr_addr);
        end
    endtask

    task automatic test_illegal_opcode();
        int s0;
        apply_reset();
        s0 = start_cnt;
        push_raw(4'hC, 4'd1, 4'd1);
        push_cmd(4'd1, 4'd7, 4'd2);
        drain("illegal", 60);
        checks++;
        if (err_opcode !== 1'b1 || start_cnt - s0 != 1) begin
            fails++;
            $display("FAIL illegal_err: got err_opcode=%b starts=%0d, expected 1 and 1", err_opcode, start_cnt - s0);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_opcode !== 1'b0) begin
            fails++;
            $display("FAIL illegal_clr: got err_opcode=%b, expected 0", err_opcode);
        end
        // Clear pulse lands on the same edge that drops a second illegal opcode.
        s0 = start_cnt;
        push_raw(4'hF, 4'd2, 4'd2);
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_opcode !== 1'b0 || busy !== 1'b0 || start_cnt != s0) begin
            fails++;
            $display("FAIL clr_priority: got err_opcode=%b busy=%b starts=%0d, expected 0 0 0",
                     err_opcode, busy, start_cnt - s0);
        end
    endtask

    task automatic test_timeout();
        int s0, w0;
        apply_reset();
        w0 = wr_cnt;
        s0 = start_cnt;
        alu_hang = 1'b1;
        push_raw(4'd2, 4'd5, 4'd3);
        wait_start("timeout", 20);
        repeat (7) tick();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: got err_timeout=%b busy=%b 7 cycles after start, expected 0 1", err_timeout, busy);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout_set: got err_timeout=%b 8 cycles after start, expected 1", err_timeout);
        end
        alu_hang = 1'b0;
        push_cmd(4'd3, 4'd6, 4'd9);
        drain("timeout", 40);
        checks++;
        if (wr_cnt - w0 != 1 || start_cnt - s0 != 2 || wr_addr !== 3'd1) begin
            fails++;
            $display("FAIL timeout_next: got writes=%0d starts=%0d wr_addr=%0d, expected 1 2 1",
                     wr_cnt - w0, start_cnt - s0, wr_addr);
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: got err_timeout=%b, expected 1", err_timeout);
        end
    endtask

    task automatic test_reset_mid();
        int s0, w0;
        apply_reset();
        alu_hang = 1'b1;
        push_raw(4'd5, 4'd9, 4'd6);
        push_raw(4'd1, 4'd2, 4'd3);
        push_raw(4'd4, 4'd4, 4'd4);
        wait_start("reset_mid", 20);
        for (int n = 0; n < 10 && (cmd_q.size() != 0 || accept_pend); n++) tick();
        tick();
        checks++;
        if (busy !== 1'b1 || {alu_opcode, alu_a, alu_b} !== 12'h596) begin
            fails++;
            $display("FAIL reset_mid_pre: got busy=%b alu=%h, expected busy=1 alu=596", busy, {alu_opcode, alu_a, alu_b});
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({alu_start, wr_en, busy, alu_opcode, alu_a, alu_b, wr_addr, wr_data, wr_flags} !== 30'h0) begin
            fails++;
            $display("FAIL reset_mid_async: got start=%b wr_en=%b busy=%b alu=%h wr=%0d/%h/%b, expected all 0",
                     alu_start, wr_en, busy, {alu_opcode, alu_a, alu_b}, wr_addr, wr_data, wr_flags);
        end
        clear_tb();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s0 = start_cnt;
        w0 = wr_cnt;
        repeat (20) tick();
        checks++;
        if (wr_cnt != w0 || start_cnt != s0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_after: got writes=%0d starts=%0d ready=%b busy=%b, expected 0 0 1 0",
                     wr_cnt - w0, start_cnt - s0, cmd_ready, busy);
        end
    endtask

    task automatic test_full_push_pop();
        int  w0;
        bit  prev_blocked, found;
        apply_reset();
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) push_cmd(4'(9 - i), 4'(2 * i + 1), 4'(i));
        prev_blocked = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            if (prev_blocked && cmd_valid && cmd_ready === 1'b1) begin
                found = 1'b1;
                checks++;
                if (alu_start !== 1'b0 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL full_push_pop_ready: got alu_start=%b busy=%b when full FIFO reopened, expected 0 1 (popping in IDLE)",
                             alu_start, busy);
                end
            end
            prev_blocked = cmd_valid && cmd_ready === 1'b0;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL full_push_pop_seen: got no full-FIFO stall followed by acceptance, expected one");
        end
        drain("full_push_pop", 200);
        checks++;
        if (wr_cnt - w0 != 8) begin
            fails++;
            $display("FAIL full_push_pop_count: got %0d writes, expected 8", wr_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal_opcode();
        test_timeout();
        test_reset_mid();
        test_full_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
